// File: rtl/store_pkg.sv
// Shared types and helpers for the store data packer.
// Latency: none, declarations only.
// Backpressure: not applicable.
package store_pkg;

   typedef enum logic [1:0] {
      SZ_B   = 2'b00,
      SZ_H   = 2'b01,
      SZ_W   = 2'b10,
      SZ_ILL = 2'b11
   } size_e;

   typedef enum logic {
      IDLE   = 1'b0,
      SECOND = 1'b1
   } state_e;

   localparam int LANES = 4;

   // Source fields of a store, kept so the second beat of a split can be rebuilt.
   typedef struct packed {
      logic [31:0] dat;
      size_e       size;
      logic [1:0]  off;
   } sreq_t;

   function automatic logic [2:0] size_bytes(input size_e s);
      case (s)
         SZ_B:    return 3'd1;
         SZ_H:    return 3'd2;
         SZ_W:    return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/store_lane_shifter.sv
// Positions a truncated store value onto byte lanes of one of its two word beats.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module store_lane_shifter
   import store_pkg::*;
(
   input  logic [31:0]      data,
   input  size_e            size,
   input  logic [1:0]       off,
   input  logic             beat_sel,
   output logic [31:0]      lane_dat,
   output logic [LANES-1:0] lane_bweb,
   output logic             crosses
);

   logic [2:0]  n;
   logic [31:0] trunc;
   logic [63:0] wide;
   logic [7:0]  be_n;
   logic [7:0]  be;

   always_comb begin
      n = size_bytes(size);
      case (size)
         SZ_B:    trunc = {24'd0, data[7:0]};
         SZ_H:    trunc = {16'd0, data[15:0]};
         SZ_W:    trunc = data;
         default: trunc = 32'd0;
      endcase
      // Shift across a two-word window; the upper word is the spill into the next beat.
      wide    = {32'd0, trunc} << {off, 3'b000};
      be_n    = (8'd1 << n) - 8'd1;
      be      = be_n << off;
      crosses = ({1'b0, off} + n) > 3'd4;
      if (beat_sel) begin
         lane_dat  = wide[63:32];
         lane_bweb = ~be[7:4];
      end else begin
         lane_dat  = wide[31:0];
         lane_bweb = ~be[3:0];
      end
   end

endmodule

// File: rtl/store_data_packer.sv
// Turns byte/half/word stores into word-aligned SRAM write beats, splitting word-crossers.
// Latency: first beat registered on the accepting edge; second beat after the first is taken.
// Backpressure: in_ready drops while a beat stalls or a split is in progress.
module store_data_packer
   import store_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter bit SPLIT_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        in_size,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic [3:0]        out_bweb,
   output logic              err
);

   if (DATA_W != 32) begin : g_data_w_check
      $error("store_data_packer supports DATA_W = 32 only");
   end

   state_e            state;
   logic              sec_pend;
   sreq_t             sav;
   logic [ADDR_W-1:0] sav_addr;

   sreq_t             sh_req;
   logic              sh_sel;
   logic [31:0]       sh_dat;
   logic [LANES-1:0]  sh_bweb;
   logic              sh_crosses;

   logic              accept;
   logic              consume;
   logic              reject;
   logic [ADDR_W-1:0] word_addr;

   // In SECOND the shifter rebuilds the spill beat from the saved request.
   always_comb begin
      if (state == SECOND) begin
         sh_req = sav;
         sh_sel = 1'b1;
      end else begin
         sh_req.dat  = in_data;
         sh_req.size = size_e'(in_size);
         sh_req.off  = in_addr[1:0];
         sh_sel      = 1'b0;
      end
   end

   store_lane_shifter u_shifter (
      .data      (sh_req.dat),
      .size      (sh_req.size),
      .off       (sh_req.off),
      .beat_sel  (sh_sel),
      .lane_dat  (sh_dat),
      .lane_bweb (sh_bweb),
      .crosses   (sh_crosses)
   );

   assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid && out_ready;
   assign reject    = (in_size == SZ_ILL) || (sh_crosses && (SPLIT_EN == 1'b0));
   assign word_addr = {in_addr[ADDR_W-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sec_pend  <= 1'b0;
         sav       <= '0;
         sav_addr  <= '0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
         out_bweb  <= 4'hF;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         if (state == IDLE) begin
            if (consume) begin
               out_valid <= 1'b0;
            end
            if (accept) begin
               if (reject) begin
                  err <= 1'b1;
               end else begin
                  out_valid <= 1'b1;
                  out_addr  <= word_addr;
                  out_data  <= sh_dat;
                  out_bweb  <= sh_bweb;
                  if (sh_crosses) begin
                     state    <= SECOND;
                     sec_pend <= 1'b1;
                     sav      <= sh_req;
                     sav_addr <= word_addr + ADDR_W'(4);
                  end
               end
            end
         end else if (consume) begin
            if (sec_pend) begin
               sec_pend <= 1'b0;
               out_addr <= sav_addr;
               out_data <= sh_dat;
               out_bweb <= sh_bweb;
            end else begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_store_data_packer.sv
// Self-checking bench: directed table, stall/reset sequences and random traffic vs a byte-level model.
module tb_store_data_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic [1:0]  in_size;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_addr;
   logic [31:0] out_data;
   logic [3:0]  out_bweb;
   logic        err;

   always #5 clk = ~clk;

   store_data_packer #(.ADDR_W(32), .DATA_W(32), .SPLIT_EN(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .in_size   (in_size),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .out_bweb  (out_bweb),
      .err       (err)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  b;
      logic        split;
   } beat_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [1:0]  sz;
      int          nb;
      logic [31:0] a0;
      logic [31:0] d0;
      logic [3:0]  w0;
      logic [31:0] a1;
      logic [31:0] d1;
      logic [3:0]  w1;
      int          e;
   } vec_t;

   beat_t exp_q[$];
   beat_t obs_q[$];
   int    checks = 0;
   int    errors = 0;
   int    err_cnt = 0;
   logic  exp_err = 1'b0;
   logic  last_acc = 1'b0;
   vec_t  vt[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Byte-by-byte model: each byte lands in the word holding its own address.
   task automatic model_req(input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] sz, output logic rej);
      int          n;
      beat_t       b0;
      beat_t       b1;
      logic [31:0] ba;
      logic [1:0]  lane;
      logic        spl;
      n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
      rej = (n == 0);
      b0.a = a & ~32'd3;
      b0.d = 32'd0;
      b0.b = 4'hF;
      b1.a = (a & ~32'd3) + 32'd4;
      b1.d = 32'd0;
      b1.b = 4'hF;
      for (int k = 0; k < n; k++) begin
         ba   = a + 32'(k);
         lane = ba[1:0];
         if (ba[31:2] == a[31:2]) begin
            b0.d[8*lane +: 8] = d[8*k +: 8];
            b0.b[lane]        = 1'b0;
         end else begin
            b1.d[8*lane +: 8] = d[8*k +: 8];
            b1.b[lane]        = 1'b0;
         end
      end
      spl      = (b1.b != 4'hF);
      b0.split = spl;
      b1.split = spl;
      if (!rej) begin
         exp_q.push_back(b0);
         if (spl) exp_q.push_back(b1);
      end
   endtask

   // One clock: check outputs against the model, advance the model, move to the next negedge.
   task automatic cycle();
      logic  exp_rdy;
      logic  split_pend;
      logic  rej;
      beat_t h;
      beat_t o;
      #1;
      split_pend = 1'b0;
      foreach (exp_q[i]) if (exp_q[i].split) split_pend = 1'b1;
      exp_rdy = !split_pend && ((exp_q.size() == 0) || out_ready);
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("err", 32'(err), 32'(exp_err));
      if (err === 1'b1) err_cnt++;
      last_acc = 1'b0;
      if (!rst) begin
         if (out_valid && out_ready && (exp_q.size() > 0)) begin
            h = exp_q.pop_front();
            chk("beat_addr", out_addr, h.a);
            chk("beat_data", out_data, h.d);
            chk("beat_bweb", 32'(out_bweb), 32'(h.b));
            o.a = out_addr;
            o.d = out_data;
            o.b = out_bweb;
            o.split = h.split;
            obs_q.push_back(o);
         end
         exp_err = 1'b0;
         if (in_valid && exp_rdy) begin
            last_acc = 1'b1;
            model_req(in_addr, in_data, in_size, rej);
            exp_err = rej;
         end
      end
      @(posedge clk);
      if (rst) begin
         exp_q.delete();
         exp_err = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      int guard = 0;
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
      in_size  = sz;
      last_acc = 1'b0;
      while (!last_acc && guard < 50) begin
         cycle();
         guard++;
      end
      in_valid = 1'b0;
      if (!last_acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=not_accepted required=accepted addr=%h", a);
      end
   endtask

   task automatic drain();
      int guard = 0;
      out_ready = 1'b1;
      while (exp_q.size() > 0 && guard < 40) begin
         cycle();
         guard++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d required=0 beats left", exp_q.size());
      end
      repeat (2) cycle();
   endtask

   initial begin
      vt[0] = '{32'h0000_1003, 32'h0000_0AE0, 2'd0, 1, 32'h1000, 32'hE000_0000, 4'b0111, 32'h0, 32'h0, 4'hF, 0};
      vt[1] = '{32'h0000_1002, 32'h1234_ABCD, 2'd1, 1, 32'h1000, 32'hABCD_0000, 4'b0011, 32'h0, 32'h0, 4'hF, 0};
      vt[2] = '{32'h0000_1001, 32'hAABB_CCDD, 2'd2, 2, 32'h1000, 32'hBBCC_DD00, 4'b0001, 32'h1004, 32'h0000_00AA, 4'b1110, 0};
      vt[3] = '{32'hFFFF_FFFF, 32'h0000_BEEF, 2'd1, 2, 32'hFFFF_FFFC, 32'hEF00_0000, 4'b0111, 32'h0, 32'h0000_00BE, 4'b1110, 0};
      vt[4] = '{32'h0000_2000, 32'h1234_5678, 2'd3, 0, 32'h0, 32'h0, 4'hF, 32'h0, 32'h0, 4'hF, 1};
      vt[5] = '{32'h0000_0040, 32'hDEAD_BEEF, 2'd2, 1, 32'h40, 32'hDEAD_BEEF, 4'b0000, 32'h0, 32'h0, 4'hF, 0};
      vt[6] = '{32'h0000_0041, 32'hFFFF_FF5A, 2'd0, 1, 32'h40, 32'h0000_5A00, 4'b1101, 32'h0, 32'h0, 4'hF, 0};
      vt[7] = '{32'h0000_0043, 32'hFFFF_1234, 2'd1, 2, 32'h40, 32'h3400_0000, 4'b0111, 32'h44, 32'h0000_0012, 4'b1110, 0};

      // Reset with a request pending: nothing may be accepted.
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_addr   = 32'h1000;
      in_data   = 32'h5555_5555;
      in_size   = 2'd2;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_bweb", 32'(out_bweb), 32'hF);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_out_addr", out_addr, 32'd0);
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed vectors.
      for (int i = 0; i < 8; i++) begin
         obs_q.delete();
         err_cnt = 0;
         out_ready = 1'b1;
         send(vt[i].a, vt[i].d, vt[i].sz);
         drain();
         chk($sformatf("v%0d_nbeats", i), 32'(obs_q.size()), 32'(vt[i].nb));
         if (vt[i].nb > 0 && obs_q.size() > 0) begin
            chk($sformatf("v%0d_b0_addr", i), obs_q[0].a, vt[i].a0);
            chk($sformatf("v%0d_b0_data", i), obs_q[0].d, vt[i].d0);
            chk($sformatf("v%0d_b0_bweb", i), 32'(obs_q[0].b), 32'(vt[i].w0));
         end
         if (vt[i].nb > 1 && obs_q.size() > 1) begin
            chk($sformatf("v%0d_b1_addr", i), obs_q[1].a, vt[i].a1);
            chk($sformatf("v%0d_b1_data", i), obs_q[1].d, vt[i].d1);
            chk($sformatf("v%0d_b1_bweb", i), 32'(obs_q[1].b), 32'(vt[i].w1));
         end
         chk($sformatf("v%0d_err_pulses", i), 32'(err_cnt), 32'(vt[i].e));
      end

      // Crossing word with the sink stalled: beat0 must hold and the input stays closed.
      obs_q.delete();
      out_ready = 1'b0;
      send(32'h0000_1001, 32'hAABB_CCDD, 2'd2);
      for (int s = 0; s < 2; s++) begin
         chk("stall_addr", out_addr, 32'h1000);
         chk("stall_data", out_data, 32'hBBCC_DD00);
         chk("stall_bweb", 32'(out_bweb), 32'b0001);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         cycle();
      end
      drain();
      chk("stall_nbeats", 32'(obs_q.size()), 32'd2);
      if (obs_q.size() > 1) begin
         chk("stall_b1_addr", obs_q[1].a, 32'h1004);
         chk("stall_b1_data", obs_q[1].d, 32'h0000_00AA);
         chk("stall_b1_bweb", 32'(obs_q[1].b), 32'b1110);
      end

      // Reset in the middle of a split: the spill beat must never appear.
      out_ready = 1'b0;
      send(32'h0000_2002, 32'h1122_3344, 2'd2);
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_bweb", 32'(out_bweb), 32'hF);
      obs_q.delete();
      out_ready = 1'b1;
      repeat (3) cycle();
      chk("midrst_no_beat", 32'(obs_q.size()), 32'd0);

      // Random traffic with random sink stalls, addresses clustered near a page and the wrap point.
      for (int r = 0; r < 600; r++) begin
         int sel;
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 1) == 1);
         in_addr   = (($urandom_range(0, 1) == 1) ? 32'h0000_1000 : 32'hFFFF_FFF8) + 32'($urandom_range(0, 15));
         in_data   = $urandom;
         sel       = $urandom_range(0, 9);
         in_size   = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
         cycle();
      end
      in_valid = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
